// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_ctrl : MIPS multiply/divide sequencer with HI/LO ownership and stall.  |
// | Optional feature: define MDU_BYPASS_EN to forward the completing result to |
// | MFHI/MFLO in the engine's final cycle.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mdu_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        in_CLK,
  input  logic        in_RST,
  input  logic        in_EN,
  input  logic [31:0] in_IS,
  input  logic        in_FLUSH,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic        out_STALL,
  output logic        out_BUSY,
  output logic [31:0] out_MDR,
  output logic [31:0] out_HI,
  output logic [31:0] out_LO
);

  localparam logic [5:0] c_F_MFHI  = 6'h10;
  localparam logic [5:0] c_F_MTHI  = 6'h11;
  localparam logic [5:0] c_F_MFLO  = 6'h12;
  localparam logic [5:0] c_F_MTLO  = 6'h13;
  localparam logic [5:0] c_F_MULT  = 6'h18;
  localparam logic [5:0] c_F_MULTU = 6'h19;
  localparam logic [5:0] c_F_DIV   = 6'h1A;
  localparam logic [5:0] c_F_DIVU  = 6'h1B;
  localparam logic [5:0] c_MUL_LOAD = 6'(MUL_CYCLES);
  localparam logic [5:0] c_DIV_LOAD = 6'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_a, r_b;
  logic        r_signed;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic        r_neg_q, r_neg_r, r_dvz;

  // ---------------------------------------------------------------- decode
  logic        w_is_r;
  logic [5:0]  w_funct;
  logic        w_mfhi, w_mflo, w_mthi, w_mtlo, w_mf;
  logic        w_mul_op, w_div_op, w_mdu_op;
  logic        w_unused;

  assign w_is_r   = (in_IS[31:26] == 6'd0);
  assign w_funct  = in_IS[5:0];
  assign w_mfhi   = w_is_r && (w_funct == c_F_MFHI);
  assign w_mflo   = w_is_r && (w_funct == c_F_MFLO);
  assign w_mthi   = w_is_r && (w_funct == c_F_MTHI);
  assign w_mtlo   = w_is_r && (w_funct == c_F_MTLO);
  assign w_mul_op = w_is_r && ((w_funct == c_F_MULT) || (w_funct == c_F_MULTU));
  assign w_div_op = w_is_r && ((w_funct == c_F_DIV)  || (w_funct == c_F_DIVU));
  assign w_mf     = w_mfhi | w_mflo;
  assign w_mdu_op = w_mf | w_mthi | w_mtlo | w_mul_op | w_div_op;
  assign w_unused = ^in_IS[25:6];

  // ---------------------------------------------------------- control
  logic w_busy, w_done, w_stall, w_accept, w_issue;

  assign w_busy = (r_state != S_IDLE);
  assign w_done = w_busy && (r_cnt == 6'd1);

`ifdef MDU_BYPASS_EN
  assign w_stall = w_busy & w_mdu_op & ~in_FLUSH & ~(w_done & w_mf);
`else
  assign w_stall = w_busy & w_mdu_op & ~in_FLUSH;
`endif

  assign w_accept = in_EN & ~w_stall & ~in_FLUSH;
  assign w_issue  = w_accept & ~w_busy & (w_mul_op | w_div_op);

  // ------------------------------------------------------ issue operands
  logic        w_op_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;

  assign w_op_signed = ~w_funct[0];
  assign w_a_neg     = w_op_signed & in_A[31];
  assign w_b_neg     = w_op_signed & in_B[31];
  assign w_a_mag     = w_a_neg ? (32'd0 - in_A) : in_A;
  assign w_b_mag     = w_b_neg ? (32'd0 - in_B) : in_B;

  // ----------------------------------------------------------- multiply
  logic [63:0] w_ma, w_mb, w_prod;

  assign w_ma   = {{32{r_signed & r_a[31]}}, r_a};
  assign w_mb   = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // ------------------------------------------------------------- divide
  logic [32:0] w_shift;
  logic [33:0] w_sub;
  logic        w_ge;
  logic [31:0] w_rem_nxt, w_quo_nxt, w_div_q, w_div_r;

  // Partial remainder with next dividend bit shifted in; no borrow means it fits.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_sub     = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge      = ~w_sub[33];
  assign w_rem_nxt = w_ge ? w_sub[31:0] : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};

  always_comb begin
    w_div_q = r_neg_q ? (32'd0 - w_quo_nxt) : w_quo_nxt;
    w_div_r = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
    if (r_dvz) begin
      w_div_q = 32'hFFFF_FFFF;
      w_div_r = r_a;
    end
  end

  logic [31:0] w_res_hi, w_res_lo;

  assign w_res_hi = (r_state == S_MUL) ? w_prod[63:32] : w_div_r;
  assign w_res_lo = (r_state == S_MUL) ? w_prod[31:0]  : w_div_q;

  // ---------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = w_mul_op ? S_MUL : S_DIV;
          w_cnt_nxt   = w_mul_op ? c_MUL_LOAD : c_DIV_LOAD;
        end
      end
      S_MUL, S_DIV: begin
        w_cnt_nxt = r_cnt - 6'd1;
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else if (in_EN) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_signed <= 1'b0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dvs    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvz    <= 1'b0;
    end else if (in_EN) begin
      if (w_issue) begin
        r_a      <= in_A;
        r_b      <= in_B;
        r_signed <= w_op_signed;
        r_quo    <= w_a_mag;
        r_rem    <= 32'd0;
        r_dvs    <= w_b_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_dvz    <= (in_B == 32'd0);
      end else if (r_state == S_DIV) begin
        r_quo <= w_quo_nxt;
        r_rem <= w_rem_nxt;
      end

      // MT* is stalled while busy, so it can never collide with the engine write.
      if (w_done) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (w_accept && w_mthi) r_hi <= in_A;
        if (w_accept && w_mtlo) r_lo <= in_A;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  always_comb begin
    out_MDR = 32'd0;
    if (w_mf && !w_stall) begin
`ifdef MDU_BYPASS_EN
      if (w_done) out_MDR = w_mfhi ? w_res_hi : w_res_lo;
      else        out_MDR = w_mfhi ? r_hi : r_lo;
`else
      out_MDR = w_mfhi ? r_hi : r_lo;
`endif
    end
  end

  assign out_STALL = w_stall;
  assign out_BUSY  = w_busy;
  assign out_HI    = r_hi;
  assign out_LO    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdu_ctrl : directed self-checking bench for mdu_ctrl (MUL_CYCLES = 4).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mdu_ctrl;

  localparam logic [5:0] c_F_MFHI  = 6'h10;
  localparam logic [5:0] c_F_MTHI  = 6'h11;
  localparam logic [5:0] c_F_MFLO  = 6'h12;
  localparam logic [5:0] c_F_MTLO  = 6'h13;
  localparam logic [5:0] c_F_MULT  = 6'h18;
  localparam logic [5:0] c_F_MULTU = 6'h19;
  localparam logic [5:0] c_F_DIV   = 6'h1A;
  localparam logic [5:0] c_F_DIVU  = 6'h1B;
  localparam logic [31:0] c_NOP    = 32'h0000_0000;

`ifdef MDU_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] is = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        stall, busy;
  logic [31:0] mdr, hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mdu_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .in_CLK   (clk),
    .in_RST   (rst),
    .in_EN    (en),
    .in_IS    (is),
    .in_FLUSH (flush),
    .in_A     (a),
    .in_B     (b),
    .out_STALL(stall),
    .out_BUSY (busy),
    .out_MDR  (mdr),
    .out_HI   (hi),
    .out_LO   (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an engine op in EX for one cycle, then leave a NOP behind it.
  task automatic issue(input logic [5:0] f, input logic [31:0] ia, input logic [31:0] ib);
    is = ins(f); a = ia; b = ib;
    #2;
    chk("issue_stall", {31'd0, stall}, 32'd0);
    cyc();
    is = c_NOP;
  endtask

  task automatic run_div(input string tag, input logic [5:0] f, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    issue(f, ia, ib);
    for (int i = 1; i <= 32; i++) begin
      #2;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      cyc();
    end
    #2;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
  endtask

  initial begin
    // Reset
    is = ins(c_F_MFHI);
    cyc(); cyc();
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    cyc();

    // MTHI then MFHI; MTLO then MFLO
    is = ins(c_F_MTHI); a = 32'h1234_5678;
    #2;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    cyc();
    is = ins(c_F_MFHI); a = 32'd0;
    #2;
    chk("mfhi_stall", {31'd0, stall}, 32'd0);
    chk("mfhi_mdr", mdr, 32'h1234_5678);
    cyc();
    is = ins(c_F_MTLO); a = 32'hCAFE_F00D;
    cyc();
    is = ins(c_F_MFLO);
    #2;
    chk("mflo_mdr", mdr, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    cyc();

    // MULT -2 * 3 with MFLO waiting behind it
    issue(c_F_MULT, 32'hFFFF_FFFE, 32'd3);
    is = ins(c_F_MFLO);
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk("mult_busy", {31'd0, busy}, 32'd1);
      chk("mult_stall", {31'd0, stall}, (i == 4 && c_BYP) ? 32'd0 : 32'd1);
      chk("mult_mdr", mdr, (i == 4 && c_BYP) ? 32'hFFFF_FFFA : 32'd0);
      cyc();
    end
    #2;
    chk("mult_idle", {31'd0, busy}, 32'd0);
    chk("mult_stall_end", {31'd0, stall}, 32'd0);
    chk("mult_mdr_end", mdr, 32'hFFFF_FFFA);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    cyc();

    // MULTU same operands with MFHI waiting behind it
    issue(c_F_MULTU, 32'hFFFF_FFFE, 32'd3);
    is = ins(c_F_MFHI);
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk("multu_stall", {31'd0, stall}, (i == 4 && c_BYP) ? 32'd0 : 32'd1);
      chk("multu_mdr", mdr, (i == 4 && c_BYP) ? 32'h0000_0002 : 32'd0);
      cyc();
    end
    #2;
    chk("multu_mdr_end", mdr, 32'h0000_0002);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    cyc();

    // DIV -7 / 2, with an MTHI that must stall and not write, and a free NOP
    issue(c_F_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 1; i <= 32; i++) begin
      is = (i == 5) ? ins(c_F_MTHI) : c_NOP;
      a  = (i == 5) ? 32'hBAD0_BAD0 : 32'd0;
      #2;
      chk("div_busy", {31'd0, busy}, 32'd1);
      chk("div_stall", {31'd0, stall}, (i == 5) ? 32'd1 : 32'd0);
      cyc();
    end
    is = c_NOP;
    #2;
    chk("div_idle", {31'd0, busy}, 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Divide-by-zero and the signed overflow corner
    run_div("divu0", c_F_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
    run_div("divovf", c_F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divs0", c_F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_div("divu", c_F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);

    // Flushed MULT and flushed MTHI do nothing
    is = ins(c_F_MULT); a = 32'd5; b = 32'd6; flush = 1'b1;
    #2;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    cyc();
    is = ins(c_F_MTHI); a = 32'hDEAD_BEEF;
    #2;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    cyc();
    is = c_NOP; flush = 1'b0;
    #2;
    chk("flush_busy2", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);

    // Reset in the middle of a divide
    is = ins(c_F_MTHI); a = 32'h5A5A_5A5A;
    cyc();
    issue(c_F_DIVU, 32'd100, 32'd3);
    repeat (9) cyc();
    #2;
    chk("rstdiv_busy_pre", {31'd0, busy}, 32'd1);
    chk("rstdiv_hi_pre", hi, 32'h5A5A_5A5A);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #2;
    chk("rstdiv_busy", {31'd0, busy}, 32'd0);
    chk("rstdiv_hi", hi, 32'd0);
    chk("rstdiv_lo", lo, 32'd0);

    // Five disabled cycles mid-divide push completion out by five
    issue(c_F_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 37; k++) begin
      en = !(k >= 3 && k <= 7);
      #2;
      chk("en_busy", {31'd0, busy}, 32'd1);
      cyc();
    end
    en = 1'b1;
    #2;
    chk("en_idle", {31'd0, busy}, 32'd0);
    chk("en_lo", lo, 32'd14);
    chk("en_hi", hi, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide unit and HI/LO registers in the 5-stage MIPS pipeline.
- Decodes the EX-stage instruction and issues MULT/MULTU/DIV/DIVU to a multi-cycle engine: fixed-latency multiply, 32-step restoring divide.
- Owns HI/LO and serves MFHI/MFLO/MTHI/MTLO.
- Raises out_STALL to hold IF/ID/EX (bubble into MEM) whenever the EX instruction needs the MDU while it is busy.

Parameters:
- MUL_CYCLES, 4, multiply latency in cycles; legal range 1..15.
- DIV_CYCLES, 32, divide latency in cycles; fixed at 32 (one quotient bit per cycle).

Ports:
- in_CLK  input  1  clock, rising edge.
- in_RST  input  1  synchronous reset, active-high.
- in_EN  input  1  global enable; 0 freezes all state (clock-enable semantics).
- in_IS  input  32  instruction currently in EX.
- in_FLUSH  input  1  EX instruction is being squashed this cycle (branch/jump redirect).
- in_A  input  32  forwarded rs operand of EX instruction.
- in_B  input  32  forwarded rt operand of EX instruction.
- out_STALL  output  1  hold IF/ID/EX and insert bubble into MEM.
- out_BUSY  output  1  engine operation in flight.
- out_MDR  output  32  HI (MFHI) or LO (MFLO) for the EX instruction; 0 otherwise.
- out_HI  output  32  architectural HI.
- out_LO  output  32  architectural LO.

Behaviour:
- Decode applies only when OP=in_IS[31:26]=0 and FUNCT=in_IS[5:0] is one of:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - Anything else is NONE.
- Reset (in_RST=1 at edge, overrides in_EN):
  - HI=LO=0, state IDLE, counter 0, divider working registers 0.
  - out_STALL=0, out_BUSY=0, out_MDR=0.
  - Reset aborts any in-flight operation with no HI/LO write.
- in_EN=0: no state changes. Outputs stay combinational from held state and current in_IS.
- FSM states:
  - IDLE: out_BUSY=0.
  - MUL: count down from MUL_CYCLES.
  - DIV: count down from 32.
- Accept condition: in_EN=1 & out_STALL=0 & in_FLUSH=0.
- Issue of MULT/MULTU/DIV/DIVU happens in IDLE on the accept condition (issue cycle T).
  - Operands, signedness and op are latched at T.
  - Next state is MUL or DIV.
  - Busy covers cycles T+1..T+N, where N = MUL_CYCLES or 32.
  - HI/LO are written at the edge closing cycle T+N; state returns to IDLE for T+N+1.
- Stall: out_STALL=1 when out_BUSY=1 and the EX instruction is any MDU op (MF*, MT*, MULT*, DIV*) and in_FLUSH=0. NONE never stalls.
- Multiply: 64-bit product, signed (MULT) or unsigned (MULTU); HI=product[63:32], LO=product[31:0].
- Divide:
  - Operand magnitudes are taken at issue.
  - Restoring shift-subtract, one bit per cycle; sign fixup applied on the final write.
  - DIV: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Result: LO=quotient, HI=remainder.
- Divide by zero (B=0): full 32-cycle latency; LO=0xFFFFFFFF, HI=A.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: write in_A to HI/LO on the accept condition. An MT* while busy is stalled, so MT* never races an engine write.
- MFHI/MFLO: out_MDR = HI/LO while not stalled; out_MDR=0 during stall.
- in_FLUSH with an MDU op in EX: no issue, no MT write, no stall. An in-flight op is older than the flush, continues and completes normally.
- Non-MDU instructions proceed freely during busy; out_STALL=0.

Optional Feature:
- Macro MDU_BYPASS_EN.
- Defined:
  - In the completion cycle T+N, out_STALL is not asserted for MF* in EX.
  - out_MDR returns the result being written that cycle (HI or LO part).
  - MT*/MULT*/DIV* still stall through T+N.
- Undefined: MF* stalls through T+N and reads HI/LO from T+N+1. Adds one cycle of MF* latency.

Test Plan:
- Reset, then MTHI A=0x12345678, then MFHI next cycle -> out_MDR=0x12345678, out_STALL=0 throughout.
- MULT A=0xFFFFFFFE(-2) B=3 at T, MFLO in EX from T+1 -> stall T+1..T+4; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7) B=2 -> busy 32 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=0 -> LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Also MULT in EX with in_FLUSH=1 -> no issue, out_BUSY stays 0.
- DIV issued, in_RST=1 at cycle T+10 -> next cycle out_BUSY=0, HI=LO=0, IDLE. in_EN=0 held for 5 cycles mid-DIV -> completion delayed by exactly 5.
- With MDU_BYPASS_EN: MULT (MUL_CYCLES=4) then MFHI -> out_STALL deasserts in T+4 with out_MDR = new HI. Without it: stall through T+4, MFHI reads in T+5.
